// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, ALU
// operation codes and the opcode/funct values the controller decodes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MR  = 4'd3,
    S_WBL = 4'd4,
    S_MW  = 4'd5,
    S_EXR = 4'd6,
    S_WBR = 4'd7,
    S_BR  = 4'd8,
    S_JMP = 4'd9,
    S_EXI = 4'd10,
    S_WBI = 4'd11
  } state_e;

  // Also consumed by the ALU, so these values are part of the datapath contract.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOR = 3'b101,
    ALU_SLT = 3'b110
  } aluc_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational instruction decoder: opcode/funct to ALU operation and a
// legal-instruction flag. An R-type with an unsupported funct is illegal.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] aluc,
  output logic       legal
);

  always_comb begin
    aluc  = ALU_ADD;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  aluc = ALU_ADD;
          FN_SUB:  aluc = ALU_SUB;
          FN_AND:  aluc = ALU_AND;
          FN_OR:   aluc = ALU_OR;
          FN_XOR:  aluc = ALU_XOR;
          FN_NOR:  aluc = ALU_NOR;
          FN_SLT:  aluc = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_J, OP_ADDI: aluc = ALU_ADD;
      OP_BEQ, OP_BNE:              aluc = ALU_SUB;
      OP_ANDI:                     aluc = ALU_AND;
      OP_ORI:                      aluc = ALU_OR;
      OP_SLTI:                     aluc = ALU_SLT;
      default:                     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Optional performance counters are built only when MC_CTRL_PERF_EN is defined.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_zero,
  output logic [1:0]  pc_source,
  output logic [2:0]  aluc,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  state_e     state_q, state_d;
  logic [2:0] dec_aluc;
  logic       dec_legal;

  mc_alu_dec u_alu_dec (
    .opcode (opcode),
    .funct  (funct),
    .aluc   (dec_aluc),
    .legal  (dec_legal)
  );

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // NOTE: every output and state_d gets a default first so no path infers a latch.
  always_comb begin
    state_d    = S_IF;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    pc_source  = 2'b00;
    aluc       = 3'b000;
    illegal    = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        aluc      = ALU_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        state_d   = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        alu_src_b = 2'b11;
        aluc      = ALU_ADD;
        if (!dec_legal) begin
          illegal = 1'b1;
        end else begin
          case (opcode)
            OP_LW, OP_SW:                       state_d = S_MA;
            OP_RTYPE:                           state_d = S_EXR;
            OP_BEQ, OP_BNE:                     state_d = S_BR;
            OP_J:                               state_d = S_JMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_EXI;
            default:                            state_d = S_IF;
          endcase
        end
      end
      S_MA: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluc      = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MR : S_MW;
      end
      S_MR: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = mem_ready ? S_WBL : S_MR;
      end
      S_WBL: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MW: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_IF : S_MW;
      end
      S_EXR: begin
        alu_src_a = 1'b1;
        aluc      = dec_aluc;
        state_d   = S_WBR;
      end
      S_WBR: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BR: begin
        alu_src_a = 1'b1;
        aluc      = ALU_SUB;
        pc_source = 2'b01;
        pc_en     = (opcode == OP_BNE) ? !zero : zero;
      end
      S_JMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
      end
      S_EXI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_zero  = (opcode == OP_ANDI) || (opcode == OP_ORI);
        aluc      = dec_aluc;
        state_d   = S_WBI;
      end
      S_WBI: reg_write = 1'b1;
      default: state_d = S_IF;
    endcase
    // Reset overrides the Mealy terms too, so no strobe leaks out mid-reset.
    if (rst) begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ext_zero   = 1'b0;
      pc_source  = 2'b00;
      aluc       = 3'b000;
      illegal    = 1'b0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;
  logic        retire;

  assign retire = (state_d == S_IF) &&
                  (state_q inside {S_WBL, S_MW, S_WBR, S_BR, S_JMP, S_WBI});

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = rst ? '0 : cycle_cnt_q;
  assign instr_cnt = rst ? '0 : instr_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule
